uart_rx: RTL and testbench

Serial receive front-end for the SIWA UART. It samples the asynchronous `RX_UART` pin and recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed bit period. Each byte is delivered to the peripheral register bank through a single-entry valid/ready holding register, with framing-error and overrun pulses. The block sits directly downstream of the `RX_UART` pin of the wrapper interface.

---
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_UART,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Sync flops reset high so reset release never looks like a start edge.
      sync_q  <= 2'b11;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], RX_UART};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
            // A byte consumed this same cycle frees the slot for the new one.
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 16: table of single frames plus
// hand-written glitch, framing, overrun, back-to-back and mid-frame reset sequences.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;
  // Pin-drive cycle to first sample showing rx_valid: 2 sync cycles + HALF + 9*CPB + 1.
  localparam int Lat = 155;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] got_data[$];
  int         got_cyc[$];
  int         ferr_cyc[$];
  int         ovr_cyc[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_nbytes;
    int         exp_nferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk      (clk),
    .reset    (reset),
    .RX_UART  (rx_pin),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_data.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cyc.push_back(cyc);
    if (overrun) ovr_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) step();
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_cyc.delete();
    ferr_cyc.delete();
    ovr_cyc.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic stop, output int c0);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_pin = frame[i];
      repeat (Cpb) step();
    end
  endtask

  initial begin
    int c, c2, r;
    logic [9:0] frame;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'hFF, 1'b0, 0, 1};

    reset    = 1'b0;
    rx_pin   = 1'b1;
    rx_ready = 1'b1;
    repeat (3) step();
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    idle(10);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send(vecs[v].data, vecs[v].stop, c);
      idle(24);
      chk($sformatf("vec%0d nbytes", v), got_data.size(), vecs[v].exp_nbytes);
      chk($sformatf("vec%0d nferr", v), ferr_cyc.size(), vecs[v].exp_nferr);
      chk($sformatf("vec%0d novr", v), ovr_cyc.size(), 0);
      if (vecs[v].exp_nbytes > 0) begin
        chk($sformatf("vec%0d data", v), (got_data.size() > 0) ? got_data[0] : -1,
            vecs[v].data);
        chk($sformatf("vec%0d latency", v), (got_cyc.size() > 0) ? got_cyc[0] - c : -1, Lat);
      end else begin
        chk($sformatf("vec%0d ferr latency", v),
            (ferr_cyc.size() > 0) ? ferr_cyc[0] - c : -1, Lat);
      end
      chk($sformatf("vec%0d busy after", v), busy, 0);
    end

    // Start glitch: 4 cycles low.
    clear_mon();
    c = cyc;
    rx_pin = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 4) rx_pin = 1'b1;
      if (k == 2) chk("glitch busy t0", busy, 0);
      if (k == 3) chk("glitch busy t0+1", busy, 1);
      if (k == 10) chk("glitch busy t0+8", busy, 1);
      if (k == 11) chk("glitch busy t0+9", busy, 0);
    end
    chk("glitch nbytes", got_data.size(), 0);
    chk("glitch nferr", ferr_cyc.size(), 0);

    // Framing error then held-low line, then recovery.
    clear_mon();
    send(8'h00, 1'b0, c);
    repeat (40) step();
    chk("ferr count", ferr_cyc.size(), 1);
    chk("ferr latency", (ferr_cyc.size() > 0) ? ferr_cyc[0] - c : -1, Lat);
    chk("ferr nbytes", got_data.size(), 0);
    chk("ferr busy wait", busy, 1);
    idle(20);
    chk("ferr busy released", busy, 0);
    send(8'h3C, 1'b1, c);
    idle(20);
    chk("ferr recover nbytes", got_data.size(), 1);
    chk("ferr recover data", (got_data.size() > 0) ? got_data[0] : -1, 8'h3C);
    chk("ferr recover nferr", ferr_cyc.size(), 1);

    // Overrun.
    clear_mon();
    rx_ready = 1'b0;
    send(8'h11, 1'b1, c);
    send(8'h22, 1'b1, c2);
    idle(20);
    chk("ovr valid", rx_valid, 1);
    chk("ovr data kept", rx_data, 8'h11);
    chk("ovr count", ovr_cyc.size(), 1);
    chk("ovr latency", (ovr_cyc.size() > 0) ? ovr_cyc[0] - c2 : -1, Lat);
    chk("ovr nferr", ferr_cyc.size(), 0);
    rx_ready = 1'b1;
    step();
    chk("ovr drained valid", rx_valid, 0);
    chk("ovr drained nbytes", got_data.size(), 1);
    chk("ovr drained data", (got_data.size() > 0) ? got_data[0] : -1, 8'h11);

    // Back-to-back frames, no idle bit.
    clear_mon();
    idle(10);
    send(8'h55, 1'b1, c);
    send(8'hAA, 1'b1, c2);
    idle(24);
    chk("b2b nbytes", got_data.size(), 2);
    chk("b2b data0", (got_data.size() > 0) ? got_data[0] : -1, 8'h55);
    chk("b2b data1", (got_data.size() > 1) ? got_data[1] : -1, 8'hAA);
    chk("b2b spacing", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 160);
    chk("b2b novr", ovr_cyc.size(), 0);

    // Reset during data bit 4 with a byte still held.
    clear_mon();
    rx_ready = 1'b0;
    send(8'hC3, 1'b1, c);
    idle(10);
    chk("rst pre valid", rx_valid, 1);
    chk("rst pre data", rx_data, 8'hC3);
    frame = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_pin = frame[i];
      repeat (Cpb) step();
    end
    rx_pin = frame[5];
    repeat (Cpb / 2) step();
    chk("rst pre busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_data", rx_data, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst overrun", overrun, 0);
    rx_pin = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    clear_mon();
    rx_ready = 1'b1;
    idle(20);
    send(8'h7E, 1'b1, c);
    idle(20);
    chk("rst after nbytes", got_data.size(), 1);
    chk("rst after data", (got_data.size() > 0) ? got_data[0] : -1, 8'h7E);
    chk("rst after latency", (got_cyc.size() > 0) ? got_cyc[0] - c : -1, Lat);
    chk("rst after nferr", ferr_cyc.size(), 0);
    chk("rst after novr", ovr_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
